// File: rtl/branch_predictor_pkg.sv
// Shared types and counter encodings for the branch predictor.
// Counter encodings are derived from the counter width so every user agrees on them.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,
        UPD_TRAIN = 2'd1,
        UPD_ALLOC = 2'd2
    } upd_action_e;

    // Weakly-taken: MSB set, remaining bits clear.
    function automatic int unsigned cnt_weak_taken(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    // Weakly-not-taken: MSB clear, remaining bits set (zero for a 1-bit counter).
    function automatic int unsigned cnt_weak_not_taken(input int unsigned w);
        return (w < 2) ? 32'd0 : ((32'd1 << (w - 1)) - 32'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Next-value logic for one saturating direction counter.
// Force-to-max has priority over increment, which has priority over decrement.
module bp_sat_counter
    import branch_predictor_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] ctr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             force_max_i,
    output logic [CNT_W-1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (force_max_i) begin
            ctr_o = '1;
        end else if (inc_i && (ctr_i != '1)) begin
            ctr_o = ctr_i + CNT_W'(1);
        end else if (dec_i && (ctr_i != '0)) begin
            ctr_o = ctr_i - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters: combinational lookup for IF,
// training from the ID-stage branch resolution, registered mispredict pulse and counter.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] if_pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_is_jump_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_tgt_i,
    output logic              mispredict_o,
    output logic [PERF_W-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(cnt_weak_taken(CNT_W));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(cnt_weak_not_taken(CNT_W));

    logic [DEPTH-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem [DEPTH];
    logic [ADDR_W-1:0] tgt_mem [DEPTH];
    logic [CNT_W-1:0]  ctr_mem [DEPTH];

    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    logic              lk_hit, up_hit, up_taken;
    logic [CNT_W-1:0]  ctr_step, ctr_new;
    upd_action_e       up_action;
    logic [ADDR_W-1:0] up_next_pc;
    logic              mis_p0;
    logic              unused_pc_lsbs;

    assign unused_pc_lsbs = ^{if_pc_i[1:0], upd_pc_i[1:0]};

    assign lk_idx = if_pc_i[IDX_W+1:2];
    assign lk_tag = if_pc_i[ADDR_W-1:IDX_W+2];
    assign lk_hit = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);

    assign pred_taken_o  = lk_hit && ctr_mem[lk_idx][CNT_W-1];
    assign pred_target_o = pred_taken_o ? tgt_mem[lk_idx] : (if_pc_i + ADDR_W'(4));

    assign up_idx   = upd_pc_i[IDX_W+1:2];
    assign up_tag   = upd_pc_i[ADDR_W-1:IDX_W+2];
    assign up_hit   = valid[up_idx] && (tag_mem[up_idx] == up_tag);
    // Unconditional jumps always train as taken, even if the outcome bit says otherwise.
    assign up_taken = upd_taken_i || upd_is_jump_i;

    bp_sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
        .ctr_i       (ctr_mem[up_idx]),
        .inc_i       (up_hit && up_taken),
        .dec_i       (up_hit && !up_taken),
        .force_max_i (upd_is_jump_i),
        .ctr_o       (ctr_step)
    );

    always_comb begin
        up_action = UPD_NONE;
        if (upd_valid_i) begin
            if (up_hit)        up_action = UPD_TRAIN;
            else if (up_taken) up_action = UPD_ALLOC;
        end
        ctr_new = ((up_action == UPD_ALLOC) && !upd_is_jump_i) ? CNT_WT : ctr_step;
    end

    // Valid bits and counters carry reset state; flush only clears valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) ctr_mem[i] <= CNT_WNT;
        end else if (flush_i) begin
            valid <= '0;
        end else if (up_action != UPD_NONE) begin
            valid[up_idx]   <= 1'b1;
            ctr_mem[up_idx] <= ctr_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush_i && (up_action != UPD_NONE) && up_taken) begin
            tag_mem[up_idx] <= up_tag;
            tgt_mem[up_idx] <= upd_target_i;
        end
    end

    assign up_next_pc = upd_taken_i ? upd_target_i : (upd_pc_i + ADDR_W'(4));
    assign mis_p0 = upd_valid_i &&
                    ((up_next_pc != upd_pred_tgt_i) || (upd_taken_i != upd_pred_taken_i));

    // Stage p0 -> output: registered mispredict pulse and saturating total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_o  <= 1'b0;
            mispred_cnt_o <= '0;
        end else begin
            mispredict_o <= mis_p0;
            if (mis_p0 && (mispred_cnt_o != '1)) mispred_cnt_o <= mispred_cnt_o + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor against a table-level reference model.
module tb_branch_predictor;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 2;
    localparam int PERF_W = 4;
    localparam int CTR_MAX = 3;
    localparam int CNT_SAT = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush_i = 1'b0;
    logic [ADDR_W-1:0] if_pc_i = '0;
    logic              pred_taken_o;
    logic [ADDR_W-1:0] pred_target_o;
    logic              upd_valid_i = 1'b0;
    logic [ADDR_W-1:0] upd_pc_i = '0;
    logic              upd_is_jump_i = 1'b0;
    logic              upd_taken_i = 1'b0;
    logic [ADDR_W-1:0] upd_target_i = '0;
    logic              upd_pred_taken_i = 1'b0;
    logic [ADDR_W-1:0] upd_pred_tgt_i = '0;
    logic              mispredict_o;
    logic [PERF_W-1:0] mispred_cnt_o;

    branch_predictor #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .if_pc_i          (if_pc_i),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_is_jump_i    (upd_is_jump_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_pred_taken_i (upd_pred_taken_i),
        .upd_pred_tgt_i   (upd_pred_tgt_i),
        .mispredict_o     (mispredict_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: one record per BTB slot, counters as plain integers 0..3.
    bit          m_valid [DEPTH];
    logic [31:0] m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];
    int          m_cnt;
    bit          m_mis;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_cnt = 0;
        m_mis = 1'b0;
    endtask

    task automatic model_predict(input logic [31:0] pc, output bit taken, output logic [31:0] tgt);
        int s = slot_of(pc);
        bit hit = m_valid[s] && (m_tag[s] == tag_of(pc));
        taken = hit && (m_ctr[s] >= 2);
        tgt   = taken ? m_tgt[s] : pc + 32'd4;
    endtask

    task automatic model_train(input logic [31:0] pc, input bit jump, input bit taken,
                               input logic [31:0] tgt);
        int s = slot_of(pc);
        bit hit = m_valid[s] && (m_tag[s] == tag_of(pc));
        if (jump) begin
            m_valid[s] = 1'b1; m_tag[s] = tag_of(pc); m_tgt[s] = tgt; m_ctr[s] = CTR_MAX;
        end else if (hit && taken) begin
            m_ctr[s] = (m_ctr[s] < CTR_MAX) ? m_ctr[s] + 1 : CTR_MAX;
            m_tgt[s] = tgt;
        end else if (hit) begin
            m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end else if (taken) begin
            m_valid[s] = 1'b1; m_tag[s] = tag_of(pc); m_tgt[s] = tgt; m_ctr[s] = 2;
        end
    endtask

    // One clock: drive at negedge, check lookup before the edge, check registered outputs after.
    task automatic cycle(input bit v, input logic [31:0] pc, input bit jump, input bit taken,
                         input logic [31:0] tgt, input bit ptaken, input logic [31:0] ptgt,
                         input bit fl, input logic [31:0] look);
        bit          e_taken;
        logic [31:0] e_tgt, actual;
        @(negedge clk);
        upd_valid_i = v; upd_pc_i = pc; upd_is_jump_i = jump; upd_taken_i = taken;
        upd_target_i = tgt; upd_pred_taken_i = ptaken; upd_pred_tgt_i = ptgt;
        flush_i = fl; if_pc_i = look;
        #1;
        model_predict(look, e_taken, e_tgt);
        check_eq("pred_taken", pred_taken_o, e_taken);
        check_eq("pred_target", pred_target_o, e_tgt);
        actual = taken ? tgt : pc + 32'd4;
        m_mis  = v && ((actual != ptgt) || (taken != ptaken));
        @(posedge clk);
        #1;
        if (fl) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        end else if (v) begin
            model_train(pc, jump, taken || jump, tgt);
        end
        if (m_mis && m_cnt < CNT_SAT) m_cnt++;
        check_eq("mispredict", mispredict_o, m_mis);
        check_eq("mispred_cnt", mispred_cnt_o, m_cnt);
    endtask

    task automatic idle(input logic [31:0] look);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, look);
    endtask

    initial begin
        bit          p_taken;
        logic [31:0] p_tgt;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state and cold lookup.
        check_eq("rst_mispredict", mispredict_o, 1'b0);
        check_eq("rst_cnt", mispred_cnt_o, 0);
        idle(32'h100);
        check_eq("cold_target_104", pred_target_o, 32'h104);

        // First taken branch allocates and mispredicts.
        cycle(1, 32'h100, 0, 1, 32'h200, 0, 32'h104, 0, 32'h100);
        check_eq("alloc_pulse", mispredict_o, 1'b1);
        idle(32'h100);
        check_eq("alloc_target_200", pred_target_o, 32'h200);

        // Two not-taken outcomes drain the counter below the taken threshold.
        cycle(1, 32'h100, 0, 0, 32'h200, 1, 32'h200, 0, 32'h100);
        cycle(1, 32'h100, 0, 0, 32'h200, 0, 32'h104, 0, 32'h100);
        idle(32'h100);
        check_eq("drained_nt", pred_taken_o, 1'b0);

        // Aliasing entries share a slot; the newer tag replaces the older.
        cycle(1, 32'h100, 0, 1, 32'h300, 0, 32'h104, 0, 32'h0);
        cycle(1, 32'h200, 0, 1, 32'h400, 0, 32'h204, 0, 32'h100);
        idle(32'h100);
        idle(32'h200);
        check_eq("alias_hit_400", pred_target_o, 32'h400);

        // Same-cycle lookup+update, a jump, and flush dropping an update.
        cycle(1, 32'h200, 0, 0, 32'h400, 1, 32'h400, 0, 32'h200);
        cycle(1, 32'h200, 0, 0, 32'h400, 0, 32'h204, 0, 32'h200);
        idle(32'h200);
        cycle(1, 32'h80, 1, 1, 32'hFFFF_FFFC, 0, 32'h84, 0, 32'h80);
        idle(32'h80);
        cycle(1, 32'h500, 0, 1, 32'h600, 0, 32'h504, 1, 32'h80);
        idle(32'h500);
        idle(32'h80);
        cycle(1, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0, 0, 32'hFFFF_FFFC);

        // Drive the 4-bit counter into saturation.
        for (int k = 0; k < 18; k++) cycle(1, 32'h40, 0, 1, 32'h44, 0, 32'h44, 0, 32'h40);
        check_eq("cnt_saturated", mispred_cnt_o, 4'hF);

        // Randomized traffic over a small address pool to exercise hits and aliases.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc, look, tgt, ptgt;
            bit v, jump, taken, ptaken, fl;
            if (n == 300) begin
                model_reset();
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
            pc    = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            look  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            tgt   = $urandom;
            v     = ($urandom_range(0, 9) < 8);
            jump  = ($urandom_range(0, 9) == 0);
            taken = jump || $urandom_range(0, 1);
            fl    = ($urandom_range(0, 29) == 0);
            model_predict(pc, p_taken, p_tgt);
            if ($urandom_range(0, 1)) begin
                ptaken = p_taken; ptgt = p_tgt;
            end else begin
                ptaken = $urandom_range(0, 1);
                ptgt   = $urandom_range(0, 1) ? (taken ? tgt : pc + 32'd4) : $urandom;
            end
            cycle(v, pc, jump, taken, tgt, ptaken, ptgt, fl, look);
        end

        // Asynchronous reset mid-cycle clears state without waiting for a clock edge.
        cycle(1, 32'h100, 0, 1, 32'h700, 0, 32'h104, 0, 32'h100);
        @(negedge clk);
        upd_valid_i = 1'b0; flush_i = 1'b0; if_pc_i = 32'h100;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("async_rst_pulse", mispredict_o, 1'b0);
        check_eq("async_rst_cnt", mispred_cnt_o, 0);
        check_eq("async_rst_pred", pred_taken_o, 1'b0);
        check_eq("async_rst_target", pred_target_o, 32'h104);
        @(negedge clk);
        rst = 1'b0;
        idle(32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
